// File: rtl/mem_access.sv
// Memory stage: byte-serial little-endian loads/stores; non-memory ops pass through combinationally.
// Store of N bytes retires (done_o) in cycle N+1 after accept, load in N+2; stall_o holds upstream meanwhile.
module mem_access #(
  parameter int ADDR_W  = 32,
  parameter int ALUOP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  input  logic [4:0]         wAddr_i,
  input  logic               wreg_i,
  output logic [4:0]         wAddr_o,
  output logic [31:0]        wData_o,
  output logic               wreg_o,
  output logic               stall_o,
  output logic               done_o,
  output logic [ADDR_W-1:0]  mem_a_o,
  output logic               mem_wr_o,
  output logic [7:0]         mem_dout_o,
  input  logic [7:0]         mem_din_i
);

  localparam logic [ALUOP_W-1:0] EXE_OP_LB  = 8'h80;
  localparam logic [ALUOP_W-1:0] EXE_OP_LH  = 8'h81;
  localparam logic [ALUOP_W-1:0] EXE_OP_LW  = 8'h83;
  localparam logic [ALUOP_W-1:0] EXE_OP_LBU = 8'h84;
  localparam logic [ALUOP_W-1:0] EXE_OP_LHU = 8'h85;
  localparam logic [ALUOP_W-1:0] EXE_OP_SB  = 8'h88;
  localparam logic [ALUOP_W-1:0] EXE_OP_SH  = 8'h89;
  localparam logic [ALUOP_W-1:0] EXE_OP_SW  = 8'h8B;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [ALUOP_W-1:0]   op_q, op_d;
  logic [4:0]           waddr_q, waddr_d;
  logic                 wreg_q, wreg_d;
  logic [31:0]          data_q, data_d;
  logic [31:0]          ld_q, ld_d;
  logic [ADDR_W-1:0]    mem_a_q, mem_a_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [7:0]           dout_q, dout_d;
  logic                 rd_vld_q, rd_vld_d;

  logic [2:0]           n_q;
  logic [2:0]           cnt_inc;
  logic [3:0]           issued;
  logic [31:0]          st_sh;
  logic [31:0]          ld_ext;

  function automatic logic [2:0] op_bytes(input logic [ALUOP_W-1:0] op);
    case (op)
      EXE_OP_LB, EXE_OP_LBU, EXE_OP_SB: op_bytes = 3'd1;
      EXE_OP_LH, EXE_OP_LHU, EXE_OP_SH: op_bytes = 3'd2;
      EXE_OP_LW, EXE_OP_SW:             op_bytes = 3'd4;
      default:                          op_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic is_store(input logic [ALUOP_W-1:0] op);
    is_store = (op == EXE_OP_SB) || (op == EXE_OP_SH) || (op == EXE_OP_SW);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      op_q     <= '0;
      waddr_q  <= 5'd0;
      wreg_q   <= 1'b0;
      data_q   <= 32'd0;
      ld_q     <= 32'd0;
      mem_a_q  <= '0;
      mem_wr_q <= 1'b0;
      dout_q   <= 8'd0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      waddr_q  <= waddr_d;
      wreg_q   <= wreg_d;
      data_q   <= data_d;
      ld_q     <= ld_d;
      mem_a_q  <= mem_a_d;
      mem_wr_q <= mem_wr_d;
      dout_q   <= dout_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    waddr_d  = waddr_q;
    wreg_d   = wreg_q;
    data_d   = data_q;
    ld_d     = ld_q;
    mem_a_d  = mem_a_q;
    mem_wr_d = mem_wr_q;
    dout_d   = dout_q;
    rd_vld_d = rd_vld_q;
    wAddr_o  = wAddr_i;
    wData_o  = wdata_i;
    wreg_o   = 1'b0;
    stall_o  = 1'b0;
    done_o   = 1'b0;

    n_q     = op_bytes(op_q);
    cnt_inc = cnt_q + 3'd1;
    st_sh   = data_q >> {cnt_inc[1:0], 3'b000};
    // Addresses already presented to the RAM: the first one, plus one per captured byte, plus one in flight.
    issued  = rd_vld_q ? ({1'b0, cnt_q} + 4'd2) : 4'd1;

    case (op_q)
      EXE_OP_LB:  ld_ext = {{24{ld_q[7]}}, ld_q[7:0]};
      EXE_OP_LH:  ld_ext = {{16{ld_q[15]}}, ld_q[15:0]};
      EXE_OP_LBU: ld_ext = {24'd0, ld_q[7:0]};
      EXE_OP_LHU: ld_ext = {16'd0, ld_q[15:0]};
      EXE_OP_LW:  ld_ext = ld_q;
      default:    ld_ext = data_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          if (op_bytes(aluop_i) != 3'd0) begin
            stall_o  = 1'b1;
            op_d     = aluop_i;
            waddr_d  = wAddr_i;
            wreg_d   = wreg_i;
            data_d   = wdata_i;
            ld_d     = 32'd0;
            mem_a_d  = addr_i[ADDR_W-1:0];
            cnt_d    = 3'd0;
            rd_vld_d = 1'b0;
            if (is_store(aluop_i)) begin
              mem_wr_d = 1'b1;
              dout_d   = wdata_i[7:0];
              state_d  = S_STORE;
            end else begin
              state_d  = S_LOAD;
            end
          end else begin
            wreg_o = wreg_i;
          end
        end
      end
      S_STORE: begin
        stall_o = 1'b1;
        if (cnt_q != n_q - 3'd1) begin
          mem_a_d = mem_a_q + ADDR_W'(1);
          dout_d  = st_sh[7:0];
          cnt_d   = cnt_inc;
        end else begin
          mem_wr_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_LOAD: begin
        stall_o  = 1'b1;
        rd_vld_d = 1'b1;
        if (issued < {1'b0, n_q}) mem_a_d = mem_a_q + ADDR_W'(1);
        if (rd_vld_q) begin
          case (cnt_q[1:0])
            2'd0:    ld_d[7:0]   = mem_din_i;
            2'd1:    ld_d[15:8]  = mem_din_i;
            2'd2:    ld_d[23:16] = mem_din_i;
            default: ld_d[31:24] = mem_din_i;
          endcase
          cnt_d = cnt_inc;
          if (cnt_q == n_q - 3'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        wAddr_o = waddr_q;
        wData_o = ld_ext;
        wreg_o  = wreg_q & ~is_store(op_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_a_o    = mem_a_q;
  assign mem_wr_o   = mem_wr_q;
  assign mem_dout_o = dout_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: byte RAM device model plus an op-level reference memory.
module tb_mem_access;

  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_LB  = 8'h80;
  localparam logic [7:0] OP_LH  = 8'h81;
  localparam logic [7:0] OP_LW  = 8'h83;
  localparam logic [7:0] OP_LBU = 8'h84;
  localparam logic [7:0] OP_LHU = 8'h85;
  localparam logic [7:0] OP_SB  = 8'h88;
  localparam logic [7:0] OP_SH  = 8'h89;
  localparam logic [7:0] OP_SW  = 8'h8B;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [7:0]  aluop_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  wAddr_i;
  logic        wreg_i;
  logic [4:0]  wAddr_o;
  logic [31:0] wData_o;
  logic        wreg_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
  logic [7:0]  mem_dout_o;
  logic [7:0]  mem_din_i = 8'd0;

  mem_access #(.ADDR_W(32), .ALUOP_W(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wAddr_i(wAddr_i), .wreg_i(wreg_i), .wAddr_o(wAddr_o),
    .wData_o(wData_o), .wreg_o(wreg_o), .stall_o(stall_o), .done_o(done_o),
    .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o), .mem_dout_o(mem_dout_o), .mem_din_i(mem_din_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  wr_t        wr_log  [$];
  int         n_chk = 0;
  int         n_fail = 0;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // RAM device: one-cycle read latency, writes committed on the edge.
  always @(posedge clk) begin
    mem_din_i <= ram_rd(mem_a_o);
    if (mem_wr_o) begin
      ram[mem_a_o] = mem_dout_o;
      wr_log.push_back('{a: mem_a_o, d: mem_dout_o});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < nbytes(op); i++) v = v | (32'(ref_rd(addr + 32'(i))) << (8 * i));
    case (op)
      OP_LB:   return (v[7]  ? 32'hFFFF_FF00 : 32'd0) | (v & 32'hFF);
      OP_LH:   return (v[15] ? 32'hFFFF_0000 : 32'd0) | (v & 32'hFFFF);
      OP_LBU:  return v & 32'hFF;
      OP_LHU:  return v & 32'hFFFF;
      default: return v;
    endcase
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a]     = b;
    ref_mem[a] = b;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_i = 1'b0;
    aluop_i = 8'($urandom);
    #1;
    check_eq("idle_stall", 32'(stall_o), 32'd0);
    check_eq("idle_wreg", 32'(wreg_o), 32'd0);
    check_eq("idle_done", 32'(done_o), 32'd0);
  endtask

  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wa, input logic wr);
    int          n       = nbytes(op);
    bit          st      = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    int          done_at = 0;
    logic [31:0] exp;
    @(negedge clk);
    valid_i = 1'b1;
    aluop_i = op;
    addr_i  = addr;
    wdata_i = data;
    wAddr_i = wa;
    wreg_i  = wr;
    #1;
    if (n == 0) begin
      check_eq("pt_stall", 32'(stall_o), 32'd0);
      check_eq("pt_wreg", 32'(wreg_o), 32'(wr));
      check_eq("pt_waddr", 32'(wAddr_o), 32'(wa));
      check_eq("pt_wdata", wData_o, data);
      check_eq("pt_memwr", 32'(mem_wr_o), 32'd0);
      return;
    end
    check_eq("acc_stall", 32'(stall_o), 32'd1);
    check_eq("acc_wreg", 32'(wreg_o), 32'd0);
    exp = ref_load(op, addr);
    wr_log.delete();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      #1;
      if (done_o) begin
        done_at = k;
        break;
      end
      check_eq("busy_stall", 32'(stall_o), 32'd1);
      check_eq("busy_wreg", 32'(wreg_o), 32'd0);
      if (!st) begin
        check_eq("ld_memwr", 32'(mem_wr_o), 32'd0);
        if (k <= n) check_eq("ld_addr", mem_a_o, addr + 32'(k - 1));
      end
    end
    check_eq("done_cycle", 32'(done_at), st ? 32'(n + 1) : 32'(n + 2));
    if (done_at != 0) begin
      check_eq("done_stall", 32'(stall_o), 32'd0);
      check_eq("done_waddr", 32'(wAddr_o), 32'(wa));
      check_eq("done_wreg", 32'(wreg_o), st ? 32'd0 : 32'(wr));
      if (!st) check_eq("ld_data", wData_o, exp);
    end
    check_eq("wr_count", 32'(wr_log.size()), st ? 32'(n) : 32'd0);
    if (st) begin
      for (int i = 0; i < n; i++) begin
        if (i < wr_log.size()) begin
          check_eq("st_addr", wr_log[i].a, addr + 32'(i));
          check_eq("st_byte", 32'(wr_log[i].d), (data >> (8 * i)) & 32'hFF);
        end
        ref_mem[addr + 32'(i)] = 8'(data >> (8 * i));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [10] = '{OP_ADD, OP_OR, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    logic [31:0] a;
    rst     = 1'b1;
    valid_i = 1'b0;
    aluop_i = 8'd0;
    addr_i  = 32'd0;
    wdata_i = 32'd0;
    wAddr_i = 5'd0;
    wreg_i  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mem_a", mem_a_o, 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr_o), 32'd0);
    check_eq("rst_dout", 32'(mem_dout_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_stall", 32'(stall_o), 32'd0);
    rst = 1'b0;

    run_op(OP_SW, 32'h100, 32'hDEAD_BEEF, 5'd1, 1'b1);
    check_eq("sw_ram_103", 32'(ram_rd(32'h103)), 32'hDE);
    poke(32'h200, 8'h80);
    run_op(OP_LB, 32'h200, 32'h0, 5'd4, 1'b1);
    check_eq("lb_value", wData_o, 32'hFFFF_FF80);
    run_op(OP_LBU, 32'h200, 32'h0, 5'd4, 1'b1);
    check_eq("lbu_value", wData_o, 32'h0000_0080);
    poke(32'h301, 8'h34);
    poke(32'h302, 8'h92);
    run_op(OP_LH, 32'h301, 32'h0, 5'd7, 1'b1);
    check_eq("lh_value", wData_o, 32'hFFFF_9234);
    run_op(OP_LHU, 32'h301, 32'h0, 5'd7, 1'b0);
    check_eq("lhu_value", wData_o, 32'h0000_9234);
    run_op(OP_LW, 32'hFFFF_FFFE, 32'h0, 5'd9, 1'b1);
    run_op(OP_ADD, 32'h0, 32'h5, 5'd3, 1'b1);
    run_op(OP_SB, 32'h10, 32'h1234_56AA, 5'd2, 1'b1);
    run_op(OP_LBU, 32'h10, 32'h0, 5'd2, 1'b1);
    check_eq("b2b_value", wData_o, 32'hAA);

    // Reset asserted while byte 1 of a word store is on the bus.
    poke(32'h400, 8'h11);
    poke(32'h401, 8'h22);
    poke(32'h402, 8'h33);
    poke(32'h403, 8'h44);
    @(negedge clk);
    valid_i = 1'b1;
    aluop_i = OP_SW;
    addr_i  = 32'h400;
    wdata_i = 32'hCAFE_F00D;
    wAddr_i = 5'd1;
    wreg_i  = 1'b1;
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_memwr", 32'(mem_wr_o), 32'd0);
    check_eq("abort_stall", 32'(stall_o), 32'd0);
    check_eq("abort_done", 32'(done_o), 32'd0);
    repeat (3) idle_cycle();
    check_eq("abort_ram_400", 32'(ram_rd(32'h400)), 32'h0D);
    check_eq("abort_ram_401", 32'(ram_rd(32'h401)), 32'hF0);
    check_eq("abort_ram_402", 32'(ram_rd(32'h402)), 32'h33);
    check_eq("abort_ram_403", 32'(ram_rd(32'h403)), 32'h44);
    ref_mem[32'h400] = 8'h0D;
    ref_mem[32'h401] = 8'hF0;

    repeat (250) begin
      case ($urandom_range(0, 3))
        0:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        1:       a = $urandom;
        default: a = 32'h1000 + 32'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 7) == 0) idle_cycle();
      else run_op(ops[$urandom_range(0, 9)], a, $urandom, 5'($urandom), 1'($urandom));
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage that consumes the execute stage's `aluop_o`, `mem_addr_o` and store-data / result outputs, and performs loads and stores over the byte-wide, single-port RAM bus.
- Multi-byte accesses are serialised little-endian, one byte per cycle; the pipeline is stalled while an access is in progress.
- Non-memory ops pass straight through to the MEM/WB latch.
- Loaded values are sign- or zero-extended to 32 bits.

Parameters:
- ADDR_W, 32, width of `mem_a_o`; the byte address increments modulo 2^ADDR_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  EX/MEM latch holds a live instruction
- aluop_i  in  `AluOpBus`  operation from execute
- addr_i  in  32  effective address from execute
- wdata_i  in  32  store data (store ops) or ALU result (all other ops)
- wAddr_i  in  5  destination register
- wreg_i  in  1  register write enable
- wAddr_o  out  5  to MEM/WB
- wData_o  out  32  to MEM/WB
- wreg_o  out  1  to MEM/WB
- stall_o  out  1  hold EX/MEM and all earlier stages
- done_o  out  1  one-cycle pulse: memory op retired
- mem_a_o  out  ADDR_W  RAM byte address
- mem_wr_o  out  1  1 = write byte this cycle
- mem_dout_o  out  8  RAM write data
- mem_din_i  in  8  RAM read data; in cycle t it is the byte at `mem_a_o` of cycle t-1

Behaviour:
- Op classes:
  - Loads: EXE_OP_LB/LH/LW/LBU/LHU, N = 1/2/4/1/2 bytes.
  - Stores: EXE_OP_SB/SH/SW, N = 1/2/4.
  - Anything else is non-memory.
- States: IDLE, LOAD, STORE, DONE. `cnt` is a 3-bit byte counter.
- Reset (rst=1 at a clock edge; applies even mid-access):
  - state=IDLE, cnt=0.
  - mem_a_o=0, mem_wr_o=0, mem_dout_o=0, done_o=0.
  - Load buffer cleared.
  - An aborted access produces no done_o and no register write.
- IDLE:
  - If valid_i=1 and the op is non-memory: wAddr_o/wData_o/wreg_o follow wAddr_i/wdata_i/wreg_i combinationally; stall_o=0.
  - If valid_i=1 and the op is a load/store (accept cycle):
    - stall_o=1 combinationally, wreg_o=0.
    - At the edge: latch op, wAddr_i, wreg_i, wdata_i; mem_a_o<=addr_i; cnt<=0.
    - Store: also mem_wr_o<=1, mem_dout_o<=wdata_i[7:0]; state<=STORE.
    - Load: state<=LOAD.
  - If valid_i=0: wreg_o=0, stall_o=0.
- STORE: stall_o=1, wreg_o=0. Each cycle one byte is written.
  - If cnt<N-1: mem_a_o<=mem_a_o+1, mem_dout_o<=byte cnt+1 of the latched data, cnt++.
  - If cnt=N-1: mem_wr_o<=0, state<=DONE.
  - An N-byte store occupies N cycles after accept; done_o appears in cycle N+1.
- LOAD: stall_o=1, wreg_o=0, mem_wr_o=0. mem_a_o advances by 1 each cycle until all N addresses have been issued.
  - In the cycles after the first issue, mem_din_i is captured into byte lane cnt, then cnt++.
  - After byte N-1 is captured: state<=DONE.
  - done_o appears in cycle N+2 after the accept edge.
- DONE (exactly one cycle):
  - done_o=1, stall_o=0.
  - wAddr_o/wreg_o come from the latched values; a store forces wreg_o=0.
  - Load wData_o:
    - LB/LH: sign-extend from bit 7/15.
    - LBU/LHU: zero-extend.
    - LW: all 32 bits.
  - State<=IDLE unconditionally. The op still visible on valid_i is stale and is never re-accepted.
  - Back-to-back memory ops therefore have a 1-cycle bubble.
- Address wrap: 0xFFFF_FFFF+1 → 0x0000_0000. Misaligned accesses are legal and need no special handling.
- mem_wr_o is 0 in every state except STORE. The RAM sees exactly N write cycles per store.
- Inputs (valid_i, aluop_i, addr_i, wdata_i, …) are ignored outside IDLE.

Test Plan:
- **Reset:** rst=1 for 2 cycles mid-SW (after byte 1) → next cycle mem_wr_o=0, stall_o=0, no done_o; RAM bytes 2–3 unchanged.
- **SW:** addr=0x100, data=0xDEADBEEF → writes 0xEF, 0xBE, 0xAD, 0xDE to 0x100–0x103 on consecutive cycles; done_o in cycle 5; wreg_o=0 throughout.
- **LB / LBU:** RAM[0x200]=0x80 → LB wData_o=0xFFFF_FF80, LBU wData_o=0x0000_0080; done_o in cycle 3; wreg_o=1 only in the DONE cycle.
- **LH / LHU / LW:** LH at 0x301 with RAM=0x34,0x92 → 0xFFFF_9234; LHU at the same address → 0x0000_9234; LW at 0xFFFF_FFFE → reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1 in that order.
- **Pass-through:** ADD result 0x5 to x3 with valid_i=1 → same cycle wData_o=0x5, wAddr_o=3, wreg_o=1, stall_o=0, no RAM activity.
- **Back-to-back:** SB 0xAA to 0x10, then LBU 0x10 → stall_o releases for exactly one DONE cycle between them; the LBU returns 0xAA; the SB is written exactly once.
